// File: rtl/instr_fetch_decode.sv
// ============================================================================
// Module   : instr_fetch_decode
// Brief    : Self-sequencing fetch/decode stage with jump loop limit and halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_decode #(
  parameter int ADDR_W    = 3,
  parameter int LAST_ADDR = 5,
  parameter int RD_LAT    = 1,
  parameter int MAX_LOOPS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [31:0]       rd_i,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [5:0]        op_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        rd_o,
  output logic [15:0]       imm_o,
  output logic [10:0]       func_o,
  output logic [2:0]        kind_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_FETCH   = 3'd1;
  localparam logic [2:0] c_LATCH   = 3'd2;
  localparam logic [2:0] c_PRESENT = 3'd3;
  localparam logic [2:0] c_HALT    = 3'd4;

  localparam logic [2:0] c_K_NOP = 3'd0;
  localparam logic [2:0] c_K_LW  = 3'd1;
  localparam logic [2:0] c_K_SW  = 3'd2;
  localparam logic [2:0] c_K_ADD = 3'd3;
  localparam logic [2:0] c_K_SUB = 3'd4;
  localparam logic [2:0] c_K_JMP = 3'd5;
  localparam logic [2:0] c_K_ILL = 3'd7;

  localparam logic [5:0] c_OP_LW  = 6'b010101;
  localparam logic [5:0] c_OP_SW  = 6'b010100;
  localparam logic [5:0] c_OP_ADD = 6'b100100;
  localparam logic [5:0] c_OP_SUB = 6'b101100;
  localparam logic [5:0] c_OP_ZERO = 6'b000000;

  localparam logic [15:0]       c_LAST_IMM  = 16'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] c_LAST_PC   = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] c_FIRST_PC  = ADDR_W'(1);
  localparam logic [1:0]        c_WAIT_LAST = 2'(RD_LAT - 1);
  localparam logic [3:0]        c_LOOP_MAX  = 4'(MAX_LOOPS);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [3:0]        r_loop_cnt;
  logic [1:0]        r_wait;
  logic              r_err;

  logic [2:0]        w_kind;
  logic [15:0]       w_imm;
  logic              w_accept;
  logic              w_fetch_done;
  logic              w_jmp_bad;
  logic [3:0]        w_loop_inc;
  logic              w_loop_hit;
  logic              w_at_last;
  logic              w_can_start;

  assign w_imm        = r_ir[15:0];
  assign w_accept     = (r_state == c_PRESENT) && dec_ready;
  assign w_fetch_done = (r_wait == c_WAIT_LAST);
  // imm=0 never reaches here as a jump, but the guard keeps the rule complete
  assign w_jmp_bad    = (w_imm > c_LAST_IMM) || (w_imm == 16'd0);
  assign w_loop_inc   = r_loop_cnt + 4'd1;
  assign w_loop_hit   = (w_loop_inc == c_LOOP_MAX);
  assign w_at_last    = (r_pc == c_LAST_PC);
  assign w_can_start  = ((r_state == c_IDLE) || (r_state == c_HALT)) && start;

  // Instruction class from the latched word
  always_comb begin
    w_kind = c_K_ILL;
    case (r_ir[31:26])
      c_OP_LW:   w_kind = c_K_LW;
      c_OP_SW:   w_kind = c_K_SW;
      c_OP_ADD:  w_kind = c_K_ADD;
      c_OP_SUB:  w_kind = c_K_SUB;
      c_OP_ZERO: w_kind = (w_imm == 16'd0) ? c_K_NOP : c_K_JMP;
      default:   w_kind = c_K_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE, c_HALT: begin
        if (start) begin
          w_next_state = c_FETCH;
        end
      end
      c_FETCH: begin
        if (w_fetch_done) begin
          w_next_state = c_LATCH;
        end
      end
      c_LATCH: begin
        w_next_state = c_PRESENT;
      end
      c_PRESENT: begin
        if (w_accept) begin
          case (w_kind)
            c_K_ILL: w_next_state = c_HALT;
            c_K_JMP: w_next_state = (w_jmp_bad || w_loop_hit) ? c_HALT : c_FETCH;
            default: w_next_state = w_at_last ? c_HALT : c_FETCH;
          endcase
        end
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  always_comb begin
    dec_valid = (r_state == c_PRESENT);
    busy      = (r_state != c_IDLE) && (r_state != c_HALT);
    done      = (r_state == c_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= '0;
      r_ir       <= '0;
      r_loop_cnt <= '0;
      r_wait     <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_can_start) begin
        r_pc       <= c_FIRST_PC;
        r_loop_cnt <= '0;
        r_wait     <= '0;
        r_err      <= 1'b0;
      end

      if (r_state == c_FETCH) begin
        r_wait <= w_fetch_done ? 2'd0 : (r_wait + 2'd1);
      end

      if (r_state == c_LATCH) begin
        r_ir <= rd_i;
      end

      if (w_accept) begin
        case (w_kind)
          c_K_ILL: begin
            r_err <= 1'b1;
          end
          c_K_JMP: begin
            if (w_jmp_bad) begin
              r_err <= 1'b1;
            end else begin
              r_loop_cnt <= w_loop_inc;
              // Target is narrowed only after the full-width range check
              if (!w_loop_hit) begin
                r_pc <= w_imm[ADDR_W-1:0];
              end
            end
          end
          default: begin
            if (!w_at_last) begin
              r_pc <= r_pc + ADDR_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign addr_o = r_pc;
  assign pc_o   = r_pc;
  assign err    = r_err;
  assign op_o   = r_ir[31:26];
  assign rs_o   = r_ir[25:21];
  assign rt_o   = r_ir[20:16];
  assign rd_o   = r_ir[15:11];
  assign imm_o  = r_ir[15:0];
  assign func_o = r_ir[10:0];
  assign kind_o = w_kind;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
// ============================================================================
// Module   : tb_instr_fetch_decode
// Brief    : Scoreboard bench for instr_fetch_decode with a registered memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        dec_ready = 1'b0;
  logic [31:0] rd_i = '0;
  logic [2:0]  addr_o, pc_o, kind_o;
  logic        dec_valid, busy, done, err;
  logic [5:0]  op_o;
  logic [4:0]  rs_o, rt_o, rd_o;
  logic [15:0] imm_o;
  logic [10:0] func_o;

  instr_fetch_decode #(.ADDR_W(3), .LAST_ADDR(5), .RD_LAT(1), .MAX_LOOPS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .addr_o(addr_o), .rd_i(rd_i),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .op_o(op_o), .rs_o(rs_o),
    .rt_o(rt_o), .rd_o(rd_o), .imm_o(imm_o), .func_o(func_o), .kind_o(kind_o),
    .pc_o(pc_o), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] W_LW  = 32'h5407_0002;  // rt=7 imm=2
  localparam logic [31:0] W_SW  = 32'h5006_0004;  // rt=6 imm=4
  localparam logic [31:0] W_ADD = 32'h9069_0800;  // rs=3 rt=9 rd=1
  localparam logic [31:0] W_SUB = 32'hB022_1800;  // rs=1 rt=2 rd=3

  logic [31:0] mem [0:7];
  logic [2:0]  ek  [0:7];
  always @(posedge clk) rd_i <= mem[addr_o];

  typedef struct packed {
    logic [2:0]  pc;
    logic [2:0]  kind;
    logic [31:0] word;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t0       = 0;

  always @(posedge clk) cyc++;

  logic [60:0] all_outs;
  assign all_outs = {addr_o, dec_valid, op_o, rs_o, rt_o, rd_o, imm_o, func_o,
                     kind_o, pc_o, busy, done, err};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Monitor: every accepted instruction is matched against the queue head
  always @(negedge clk) begin
    if (rst && dec_valid && dec_ready) begin
      check($sformatf("sb_has_entry@pc%0d", pc_o), 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("pc_order(exp %0d)", e.pc), 64'(pc_o), 64'(e.pc));
        check($sformatf("kind@pc%0d", e.pc), 64'(kind_o), 64'(e.kind));
        check($sformatf("fields@pc%0d", e.pc), 64'({op_o, rs_o, rt_o, imm_o, rd_o, func_o}),
              64'({e.word, e.word[15:0]}));
      end
    end
  end

  task automatic load_std();
    for (int i = 0; i < 8; i++) begin mem[i] = 32'h0; ek[i] = 3'd0; end
    mem[1] = W_LW;  ek[1] = 3'd1;
    mem[2] = W_SW;  ek[2] = 3'd2;
    mem[3] = W_ADD; ek[3] = 3'd3;
    mem[4] = W_SUB; ek[4] = 3'd4;
    mem[5] = 32'h0; ek[5] = 3'd0;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) sb.push_back('{pc: 3'(p), kind: ek[p], word: mem[p]});
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!dec_valid && k < 20) begin @(posedge clk); #1; k++; end
    check(name, 64'(dec_valid), 64'd1);
  endtask

  task automatic wait_done(input string name, output int edges);
    int k = 0;
    while (!done && k < 200) begin @(posedge clk); #1; k++; end
    check({name, "_reached_halt"}, 64'(done), 64'd1);
    edges = cyc - t0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    int edges;
    load_std();

    // Reset values, then a reset hitting a presented instruction
    #12;
    check("reset_outputs", 64'(all_outs), 64'd0);
    @(negedge clk) rst = 1'b1;
    pulse_start();
    wait_valid("midrun_valid");
    @(negedge clk) rst = 1'b0;
    #1;
    check("midrun_reset_outputs", 64'(all_outs), 64'd0);
    #10;
    @(negedge clk) rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_no_start", 64'({addr_o, busy, done, dec_valid}), 64'd0);

    // Straight fetch with dec_ready high
    dec_ready = 1'b1;
    push_range(1, 5);
    pulse_start();
    k = 0;
    while (!dec_valid && k < 10) begin @(posedge clk); #1; k++; end
    check("first_valid_latency", 64'(k), 64'd2);
    wait_done("straight", edges);
    check("straight_run_edges", 64'(edges), 64'd15);
    check("straight_end", 64'({done, err, busy, pc_o}), 64'({1'b1, 1'b0, 1'b0, 3'd5}));
    check("straight_sb_drained", 64'(sb.size()), 64'd0);

    // Backpressure on the SW at address 2
    dec_ready = 1'b0;
    push_range(1, 5);
    pulse_start();
    wait_valid("bp_valid_pc1");
    @(negedge clk) dec_ready = 1'b1;
    @(posedge clk);
    #1 dec_ready = 1'b0;
    wait_valid("bp_valid_pc2");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_stall_%0d", i),
            64'({dec_valid, op_o, rt_o, imm_o, pc_o, addr_o}),
            64'({1'b1, 6'b010100, 5'd6, 16'd4, 3'd2, 3'd2}));
    end
    @(posedge clk);
    #1 dec_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_pc_after_accept", 64'({dec_valid, addr_o}), 64'({1'b0, 3'd3}));
    wait_done("bp", edges);
    check("bp_sb_drained", 64'(sb.size()), 64'd0);

    // Jump back to 1 until the loop limit
    mem[5] = 32'h0000_0001; ek[5] = 3'd5;
    push_range(1, 5);
    push_range(1, 5);
    pulse_start();
    wait_done("loop", edges);
    check("loop_end", 64'({done, err, busy, pc_o}), 64'({1'b1, 1'b0, 1'b0, 3'd5}));
    check("loop_sb_drained", 64'(sb.size()), 64'd0);

    // Illegal opcode at address 3
    load_std();
    mem[3] = 32'hFC00_0000; ek[3] = 3'd7;
    push_range(1, 3);
    pulse_start();
    wait_done("illegal", edges);
    check("illegal_end", 64'({done, err, busy, pc_o}), 64'({1'b1, 1'b1, 1'b0, 3'd3}));
    check("illegal_sb_drained", 64'(sb.size()), 64'd0);

    // Jump target out of range at address 5
    load_std();
    mem[5] = 32'h0000_0006; ek[5] = 3'd5;
    push_range(1, 5);
    pulse_start();
    check("restart_clears_err", 64'({err, addr_o, busy}), 64'({1'b0, 3'd1, 1'b1}));
    wait_done("badjump", edges);
    check("badjump_end", 64'({done, err, busy, pc_o}), 64'({1'b1, 1'b1, 1'b0, 3'd5}));
    check("badjump_sb_drained", 64'(sb.size()), 64'd0);

    // Restart from an error halt; start pulses while busy are ignored
    load_std();
    push_range(1, 5);
    pulse_start();
    check("restart_from_err", 64'({err, addr_o, busy}), 64'({1'b0, 3'd1, 1'b1}));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
    end
    wait_done("restart", edges);
    check("restart_run_edges", 64'(edges), 64'd15);
    check("restart_end", 64'({done, err, busy, pc_o}), 64'({1'b1, 1'b0, 1'b0, 3'd5}));
    check("restart_sb_drained", 64'(sb.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
